// File: rtl/mem_write_arbiter.sv
// Arbitrates NUM_REQ write requesters onto one registered membank write port.
// Classes: urgent (waited MAX_WAIT cycles) > forcewrite > normal, round-robin within a class.
package memory_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic              en;
        logic              forcewrite;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } write_req_pkt;
endpackage

module mem_write_arbiter
    import memory_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  write_req_pkt               write_req [NUM_REQ],
    input  logic                       stall_back,
    output write_req_pkt               membank_write_req,
    output logic [NUM_REQ-1:0]         stall_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 8;

    logic [NUM_REQ-1:0] en_vec;
    logic [NUM_REQ-1:0] force_vec;
    logic [NUM_REQ-1:0] urgent_vec;
    logic [NUM_REQ-1:0] class_vec;
    logic [NUM_REQ-1:0] grant_vec;

    write_req_pkt       out_reg;
    logic [ID_W-1:0]    grant_id_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               grant_valid;
    logic               accept;

    assign accept = !out_reg.en || !stall_back;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [CNT_W-1:0] wait_cnt_reg;

            assign en_vec[gi]     = write_req[gi].en;
            assign force_vec[gi]  = write_req[gi].en && write_req[gi].forcewrite;
            // Mask with en: the counter only clears on the edge after en drops.
            assign urgent_vec[gi] = write_req[gi].en && (wait_cnt_reg == CNT_W'(MAX_WAIT));
            assign grant_vec[gi]  = grant_valid && (winner == ID_W'(gi));
            assign stall_out[gi]  = rst || (en_vec[gi] && !grant_vec[gi]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wait_cnt_reg <= '0;
                end else if (en_vec[gi] && !grant_vec[gi]) begin
                    if (wait_cnt_reg != CNT_W'(MAX_WAIT)) begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end else begin
                    wait_cnt_reg <= '0;
                end
            end
        end
    endgenerate

    assign class_vec = (|urgent_vec) ? urgent_vec :
                       (|force_vec)  ? force_vec  : en_vec;

    always_comb begin : rr_scan
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!found && class_vec[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign grant_valid = accept && found;
    assign rr_ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg      <= '0;
            grant_id_reg <= '0;
            rr_ptr_reg   <= '0;
        end else if (accept) begin
            if (grant_valid) begin
                out_reg      <= write_req[winner];
                grant_id_reg <= winner;
                rr_ptr_reg   <= rr_ptr_next;
            end else begin
                out_reg.en   <= 1'b0;
            end
        end
    end

    assign membank_write_req = out_reg;
    assign grant_id          = grant_id_reg;

endmodule
